// File: rtl/adjust_column_reader.sv
// Read-side sequencer for the adjust-data dual-port memory (port B).
// Walks a swatch of adjust words starting at a latched base address and
// prefetches the next word whenever the column advances. The offset wraps
// to 0 after the last word of the swatch, and column advances that arrive
// while a fetch is still in flight are flagged as a sticky overrun.
module adjust_column_reader #(
  parameter int AW     = 12,
  parameter int DW     = 16,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          stop,
  input  logic [AW-1:0] base_addr,
  input  logic [AW:0]   word_count,
  input  logic          col_adv,
  input  logic          clear_err,
  output logic [AW-1:0] addrb,
  input  logic [DW-1:0] dob,
  output logic [DW-1:0] adj_data,
  output logic          adj_valid,
  output logic [AW-1:0] col_idx,
  output logic          busy,
  output logic          wrap,
  output logic          overrun
);

  // Wide enough to count up to RD_LAT without overflow.
  localparam int CW = $clog2(RD_LAT + 1) + 1;

  typedef enum logic [1:0] {IDLE, FETCH, READY} state_t;

  state_t        state_reg, state_next;
  logic [CW-1:0] fcnt_reg, fcnt_next;
  logic [AW-1:0] base_reg, base_next;
  logic [AW:0]   count_reg, count_next;

  logic [AW-1:0] addrb_next;
  logic [DW-1:0] adj_data_next;
  logic          adj_valid_next;
  logic [AW-1:0] col_idx_next;
  logic          wrap_next;
  logic          overrun_next;

  logic          last_word;
  logic [AW-1:0] next_off;
  logic          fetch_done;
  logic          overrun_event;

  // Offset arithmetic: wrap to 0 after the last word. The address adds
  // modulo 2^AW, so a swatch can straddle the top of memory.
  assign last_word     = ({1'b0, col_idx} == (count_reg - {{AW{1'b0}}, 1'b1}));
  assign next_off      = last_word ? '0 : (col_idx + 1'b1);
  // The read has settled RD_LAT+1 edges after addrb was updated.
  assign fetch_done    = (state_reg == FETCH) && (fcnt_reg == CW'(RD_LAT));
  // A restart or abort in the same cycle overrides an early column advance.
  assign overrun_event = (state_reg == FETCH) && col_adv && !start && !stop;
  assign busy          = (state_reg != IDLE);

  // State register and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      fcnt_reg  <= '0;
      base_reg  <= '0;
      count_reg <= '0;
      addrb     <= '0;
      adj_data  <= '0;
      adj_valid <= 1'b0;
      col_idx   <= '0;
      wrap      <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state_reg <= state_next;
      fcnt_reg  <= fcnt_next;
      base_reg  <= base_next;
      count_reg <= count_next;
      addrb     <= addrb_next;
      adj_data  <= adj_data_next;
      adj_valid <= adj_valid_next;
      col_idx   <= col_idx_next;
      wrap      <= wrap_next;
      overrun   <= overrun_next;
    end
  end

  // Next-state logic: stop beats start, start beats everything else.
  always_comb begin
    state_next = state_reg;
    if (stop) begin
      state_next = IDLE;
    end else if (start) begin
      state_next = FETCH;
    end else begin
      unique case (state_reg)
        FETCH:   if (fetch_done) state_next = READY;
        READY:   if (col_adv)    state_next = FETCH;
        default: state_next = state_reg;
      endcase
    end
  end

  // Next values for the datapath and outputs.
  always_comb begin
    fcnt_next      = fcnt_reg;
    base_next      = base_reg;
    count_next     = count_reg;
    addrb_next     = addrb;
    adj_data_next  = adj_data;
    adj_valid_next = adj_valid;
    col_idx_next   = col_idx;
    wrap_next      = 1'b0;

    if (stop) begin
      // Abort keeps the pointer and last data visible, only validity drops.
      adj_valid_next = 1'b0;
    end else if (start) begin
      // Restart discards any in-flight read; a zero length means a full 2^AW.
      base_next      = base_addr;
      count_next     = (word_count == '0) ? {1'b1, {AW{1'b0}}} : word_count;
      addrb_next     = base_addr;
      col_idx_next   = '0;
      adj_valid_next = 1'b0;
      fcnt_next      = '0;
    end else begin
      unique case (state_reg)
        FETCH: begin
          if (fetch_done) begin
            adj_data_next  = dob;
            adj_valid_next = 1'b1;
          end else begin
            fcnt_next = fcnt_reg + 1'b1;
          end
        end
        READY: begin
          if (col_adv) begin
            col_idx_next   = next_off;
            addrb_next     = base_reg + next_off;
            adj_valid_next = 1'b0;
            wrap_next      = last_word;
            fcnt_next      = '0;
          end
        end
        default: ;
      endcase
    end

    // Sticky error: a new event takes priority over a clear.
    if (overrun_event) begin
      overrun_next = 1'b1;
    end else if (clear_err) begin
      overrun_next = 1'b0;
    end else begin
      overrun_next = overrun;
    end
  end

endmodule
